bit_serial_adder: RTL

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_adder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bit_serial_adder: one-bit-per-cycle add/subtract with registered NZCV flags
// Rev 1.0
// ---------------------------------------------------------------------------

module full_adder (
  input  logic A_in,
  input  logic B_in,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = A_in ^ B_in ^ carry_in;
  assign carry_out = (A_in & B_in) | (carry_in & (A_in ^ B_in));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             neg_q, zero_q, cout_q, ovf_q;
  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] acc_next;

  full_adder u_fa (
    .A_in      (a_q[0]),
    .B_in      (b_q[0]),
    .carry_in  (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  assign last_bit = (state_q == S_ADD) && (cnt_q == LAST_CNT);
  assign acc_next = {fa_sum, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADD;
      S_ADD:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == S_IDLE);
    done  = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
        a_q     <= A;
        b_q     <= B ^ {WIDTH{subtract}};
        carry_q <= subtract;
        cnt_q   <= '0;
      end else if (state_q == S_ADD) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        acc_q   <= acc_next;
        carry_q <= fa_cout;
        cnt_q   <= cnt_q + 1'b1;
      end
      // carry_q still holds the carry into the MSB on the final bit.
      if (last_bit) begin
        result_q <= acc_next;
        neg_q    <= fa_sum;
        zero_q   <= (acc_next == '0);
        cout_q   <= fa_cout;
        ovf_q    <= carry_q ^ fa_cout;
      end
    end
  end

  assign result    = result_q;
  assign negative  = neg_q;
  assign zero      = zero_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire
